// File: rtl/variable_clk_seq.sv
// Programmable tempo divider: toggles variableClk every user_input0 cycles of clk100hz.
// A zero half-period stops the divider and holds the output low.
module variable_clk_seq #(
    parameter int WIDTH = 10
) (
    input  logic             clk100hz,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] user_input0,
    output logic             variableClk
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_clk_q;
    logic [WIDTH:0]   w_cnt_inc;
    logic             w_phase_done;

    // Compare cnt+1 against N in WIDTH+1 bits so N-1 never has to be formed.
    assign w_cnt_inc    = {1'b0, r_cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign w_phase_done = (w_cnt_inc >= {1'b0, user_input0});

    always_ff @(posedge clk100hz) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_clk_q <= 1'b0;
        end else if (user_input0 == '0) begin
            r_cnt   <= '0;
            r_clk_q <= 1'b0;
        end else if (w_phase_done) begin
            r_cnt   <= '0;
            r_clk_q <= ~r_clk_q;
        end else begin
            r_cnt   <= w_cnt_inc[WIDTH-1:0];
        end
    end

    assign variableClk = r_clk_q;

endmodule

// File: tb/tb_variable_clk_seq.sv
// Directed bench for variable_clk_seq: records toggle edges per segment and checks
// them against hand-computed edge numbers.
module tb_variable_clk_seq;

    localparam int WIDTH = 10;

    logic             clk100hz = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] user_input0 = '0;
    logic             variableClk;

    int n_cmp  = 0;
    int n_fail = 0;
    int tq[$];

    variable_clk_seq #(.WIDTH(WIDTH)) dut (
        .clk100hz   (clk100hz),
        .rst_n      (rst_n),
        .user_input0(user_input0),
        .variableClk(variableClk)
    );

    always #5 clk100hz = ~clk100hz;

    task automatic tick();
        @(posedge clk100hz);
        #1;
    endtask

    // Segment-relative edge numbers (1-based) at which the output changed.
    task automatic run(input int n);
        logic prev;
        tq.delete();
        for (int i = 1; i <= n; i++) begin
            prev = variableClk;
            tick();
            if (variableClk !== prev) tq.push_back(i);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held two edges with a nonzero period applied
        rst_n       = 1'b0;
        user_input0 = 10'd200;
        tick();
        chk("rst1_out", int'(variableClk), 0);
        chk("rst1_cnt", int'(dut.r_cnt), 0);
        tick();
        chk("rst2_out", int'(variableClk), 0);
        chk("rst2_cnt", int'(dut.r_cnt), 0);

        // N=200 steady: toggles at 200,400,600,800,1000
        rst_n = 1'b1;
        run(1023);
        chk("A_ntog", tq.size(), 5);
        chk("A_t0", tq[0], 200);
        chk("A_t1", tq[1], 400);
        chk("A_t2", tq[2], 600);
        chk("A_t3", tq[3], 800);
        chk("A_t4", tq[4], 1000);
        chk("A_lvl", int'(variableClk), 1);
        chk("A_cnt", int'(dut.r_cnt), 23);

        // Advance to cnt=150 within the high phase
        run(127);
        chk("preB_ntog", tq.size(), 0);
        chk("preB_cnt", int'(dut.r_cnt), 150);

        // Grow to 300 mid-phase: toggle 150 edges later, then every 300
        user_input0 = 10'd300;
        run(650);
        chk("B_ntog", tq.size(), 2);
        chk("B_t0", tq[0], 150);
        chk("B_t1", tq[1], 450);
        chk("B_lvl", int'(variableClk), 1);
        chk("B_cnt", int'(dut.r_cnt), 200);

        // Shrink to 25 with cnt=200: immediate toggle, then every 25
        user_input0 = 10'd25;
        run(80);
        chk("C_ntog", tq.size(), 4);
        chk("C_t0", tq[0], 1);
        chk("C_t1", tq[1], 26);
        chk("C_t2", tq[2], 51);
        chk("C_t3", tq[3], 76);
        chk("C_lvl", int'(variableClk), 1);

        // N=0: forced low on first edge, counter cleared
        user_input0 = '0;
        run(103);
        chk("D_ntog", tq.size(), 1);
        chk("D_t0", tq[0], 1);
        chk("D_lvl", int'(variableClk), 0);
        chk("D_cnt", int'(dut.r_cnt), 0);

        // N=700 from stopped: first rise on edge 700
        user_input0 = 10'd700;
        run(4023);
        chk("E_ntog", tq.size(), 5);
        chk("E_t0", tq[0], 700);
        chk("E_t1", tq[1], 1400);
        chk("E_t2", tq[2], 2100);
        chk("E_t3", tq[3], 2800);
        chk("E_t4", tq[4], 3500);
        chk("E_lvl", int'(variableClk), 1);
        chk("E_cnt", int'(dut.r_cnt), 523);

        // N=1023 (max) from cnt=523: toggle at 500, then 1023 later
        user_input0 = 10'd1023;
        run(1600);
        chk("F_ntog", tq.size(), 2);
        chk("F_t0", tq[0], 500);
        chk("F_t1", tq[1], 1523);
        chk("F_lvl", int'(variableClk), 1);
        chk("F_cnt", int'(dut.r_cnt), 77);

        // N=1: toggle on every edge
        user_input0 = 10'd1;
        run(6);
        chk("G_ntog", tq.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("G_t%0d", i), tq[i], i + 1);
        chk("G_lvl", int'(variableClk), 1);

        // Reset mid-run overrides a nonzero period
        rst_n = 1'b0;
        tick();
        chk("R_out", int'(variableClk), 0);
        chk("R_cnt", int'(dut.r_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
